uart_rx_line: RTL and testbench

UART line receiver, the receive-side counterpart of the string transmitter. It deserialises 8N1 frames from the `uart_rx` pin and assembles the characters into a 32-character packed string buffer. When a terminator arrives it flags a complete line. The `string`/`string_len` output packing matches the transmit-side string sender, so a received line can be fed straight back into it to echo.

---
 rtl/uart_rx_line.sv | 164 ++++++++++++++++
 tb/tb_uart_rx_line.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_line.sv
// 8N1 UART receiver that assembles characters into a 32-byte packed line buffer.
// A terminator flags a complete line; the buffer packing matches the string transmitter.
module uart_rx_line #(
    parameter int          SYS_FREQ = 125,
    parameter int          BAUD     = 115200,
    parameter logic [7:0]  TERM     = 8'h0D
) (
    input  logic           clk,
    input  logic           reset_p,
    input  logic           uart_rx,
    output logic [255:0]   line_string,
    output logic [5:0]     string_len,
    output logic           line_valid,
    output logic           overflow,
    output logic           frame_err,
    output logic           rx_busy
);

    localparam int DIV  = SYS_FREQ * 1_000_000 / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_t;

    logic [1:0]    sync_q;
    logic          rx_s;
    logic          rx_prev_q;
    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [255:0]  buf_q, buf_d;
    logic [5:0]    len_q, len_d;
    logic          done_q, done_d;
    logic          line_valid_q, line_valid_d;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_busy_q, rx_busy_d;
    logic          byte_ok;

    assign rx_s = sync_q[1];

    // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        buf_d        = buf_q;
        len_d        = len_q;
        done_d       = done_q;
        line_valid_d = 1'b0;
        overflow_d   = 1'b0;
        frame_err_d  = 1'b0;
        byte_ok      = 1'b0;

        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s && rx_prev_q) state_d = START;
            end
            START: begin
                if (cnt_q == CW'(HALF - 1)) begin
                    cnt_d   = '0;
                    bit_d   = '0;
                    state_d = rx_s ? IDLE : DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STOP: begin
                if (cnt_q == CW'(DIV - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        byte_ok = 1'b1;
                        state_d = IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_HIGH;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_HIGH: begin
                if (rx_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // LF is dropped outright, so it neither clears a finished line nor adds to it.
        if (byte_ok && shift_q != 8'h0A) begin
            if (done_q) begin
                buf_d  = '0;
                len_d  = '0;
                done_d = 1'b0;
            end
            if (shift_q == TERM) begin
                if (len_d != 6'd0) begin
                    line_valid_d = 1'b1;
                    done_d       = 1'b1;
                end
            end else if (len_d == 6'd32) begin
                overflow_d = 1'b1;
            end else begin
                buf_d = {buf_d[247:0], shift_q};
                len_d = len_d + 6'd1;
            end
        end

        rx_busy_d = (state_d != IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (reset_p) begin
            sync_q       <= 2'b11;
            rx_prev_q    <= 1'b1;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            buf_q        <= '0;
            len_q        <= '0;
            done_q       <= 1'b0;
            line_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_busy_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], uart_rx};
            rx_prev_q    <= rx_s;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            buf_q        <= buf_d;
            len_q        <= len_d;
            done_q       <= done_d;
            line_valid_q <= line_valid_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
            rx_busy_q    <= rx_busy_d;
        end
    end

    assign line_string = buf_q;
    assign string_len  = len_q;
    assign line_valid  = line_valid_q;
    assign overflow    = overflow_q;
    assign frame_err   = frame_err_q;
    assign rx_busy     = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_line.sv
// Self-checking bench for uart_rx_line: directed scenarios plus random lines,
// compared against a queue-based model of the line-assembly rules.
module tb_uart_rx_line;

    localparam int         DIV  = 16;
    localparam logic [7:0] TERM = 8'h0D;

    logic         clk = 1'b0;
    logic         reset_p;
    logic         uart_rx;
    logic [255:0] line_string;
    logic [5:0]   string_len;
    logic         line_valid, overflow, frame_err, rx_busy;

    uart_rx_line #(.SYS_FREQ(1), .BAUD(62500), .TERM(TERM)) dut (
        .clk         (clk),
        .reset_p     (reset_p),
        .uart_rx     (uart_rx),
        .line_string (line_string),
        .string_len  (string_len),
        .line_valid  (line_valid),
        .overflow    (overflow),
        .frame_err   (frame_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Pulse monitor, sampled on the falling edge.
    int           lv_cnt = 0, ov_cnt = 0, fe_cnt = 0, multi_cnt = 0, wide_cnt = 0;
    logic         lv_prev = 1'b0, ov_prev = 1'b0, fe_prev = 1'b0;
    logic [255:0] snap_str = '0;
    logic [5:0]   snap_len = '0;

    always @(negedge clk) begin
        if (line_valid) begin
            lv_cnt   = lv_cnt + 1;
            snap_str = line_string;
            snap_len = string_len;
        end
        if (overflow)  ov_cnt = ov_cnt + 1;
        if (frame_err) fe_cnt = fe_cnt + 1;
        if ((32'(line_valid) + 32'(overflow) + 32'(frame_err)) > 1) multi_cnt = multi_cnt + 1;
        if ((line_valid && lv_prev) || (overflow && ov_prev) || (frame_err && fe_prev))
            wide_cnt = wide_cnt + 1;
        lv_prev = line_valid;
        ov_prev = overflow;
        fe_prev = frame_err;
    end

    // Reference model: the line as a queue of characters, first char at index 0.
    logic [7:0] m_chars[$];
    logic       m_done = 1'b0;
    int         m_lv = 0, m_ov = 0, m_fe = 0;

    function automatic logic [255:0] exp_string();
        logic [255:0] s = '0;
        int n = m_chars.size();
        for (int j = 0; j < n; j++) s[8*(n-1-j) +: 8] = m_chars[j];
        return s;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        if (b == 8'h0A) return;
        if (m_done) begin
            m_chars.delete();
            m_done = 1'b0;
        end
        if (b == TERM) begin
            if (m_chars.size() > 0) begin
                m_lv++;
                m_done = 1'b1;
            end
        end else if (m_chars.size() == 32) begin
            m_ov++;
        end else begin
            m_chars.push_back(b);
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        uart_rx = 1'b0;
        tick(DIV);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            tick(DIV);
        end
        uart_rx = stop_ok;
        tick(DIV);
        uart_rx = 1'b1;
        if (stop_ok) model_byte(b);
        else         m_fe++;
    endtask

    task automatic check_state(input string tag);
        tick(2);
        check({tag, "/lv"},  256'(lv_cnt), 256'(m_lv));
        check({tag, "/ov"},  256'(ov_cnt), 256'(m_ov));
        check({tag, "/fe"},  256'(fe_cnt), 256'(m_fe));
        check({tag, "/len"}, 256'(string_len), 256'(m_chars.size()));
        check({tag, "/str"}, line_string, exp_string());
    endtask

    task automatic check_line(input string tag);
        check_state(tag);
        check({tag, "/snap_len"}, 256'(snap_len), 256'(m_chars.size()));
        check({tag, "/snap_str"}, snap_str, exp_string());
    endtask

    initial begin
        reset_p = 1'b1;
        uart_rx = 1'b1;
        tick(3);
        reset_p = 1'b0;
        tick(1);
        check("rst/str",  line_string, '0);
        check("rst/len",  256'(string_len), 256'(0));
        check("rst/busy", 256'(rx_busy), 256'(0));
        check("rst/pulses", 256'({line_valid, overflow, frame_err}), 256'(0));

        // Basic line
        send_byte("H", 1'b1);
        send_byte("I", 1'b1);
        send_byte(TERM, 1'b1);
        check_line("hi");
        check("hi/lit", line_string, 256'(16'h4849));

        // Short low glitch on the line
        uart_rx = 1'b0;
        tick(4);
        check("glitch/busy_hi", 256'(rx_busy), 256'(1));
        uart_rx = 1'b1;
        tick(DIV / 2 + 3);
        check("glitch/busy_lo", 256'(rx_busy), 256'(0));
        check_state("glitch");

        // Frame error then recovery
        send_byte(8'h41, 1'b0);
        tick(20);
        check_state("ferr");
        send_byte("A", 1'b1);
        send_byte(TERM, 1'b1);
        check_line("ferr_a");
        check("ferr_a/lit", line_string, 256'(8'h41));

        // Overflow: 33 characters then CR
        for (int i = 0; i < 33; i++) send_byte("a", 1'b1);
        check_state("ovf_pre");
        send_byte(TERM, 1'b1);
        check_line("ovf");
        check("ovf/len32", 256'(string_len), 256'(32));

        // Empty line with CRLF, then a real line
        send_byte(TERM, 1'b1);
        send_byte(8'h0A, 1'b1);
        check_state("empty");
        send_byte("B", 1'b1);
        send_byte(TERM, 1'b1);
        check_line("b");
        check("b/lit", line_string, 256'(8'h42));

        // Reset in the middle of a frame
        send_byte("Q", 1'b1);
        check_state("pre_rst");
        uart_rx = 1'b0;
        tick(DIV);
        uart_rx = 1'b0;
        tick(DIV);
        uart_rx = 1'b1;
        tick(DIV);
        reset_p = 1'b1;
        tick(1);
        reset_p = 1'b0;
        m_chars.delete();
        m_done = 1'b0;
        check("mrst/str",  line_string, '0);
        check("mrst/len",  256'(string_len), 256'(0));
        check("mrst/busy", 256'(rx_busy), 256'(0));
        check("mrst/pulses", 256'({line_valid, overflow, frame_err}), 256'(0));
        tick(4);
        send_byte("Z", 1'b1);
        send_byte(TERM, 1'b1);
        check_line("z");
        check("z/lit", line_string, 256'(8'h5A));

        // Random lines, with occasional LF, stray CR, frame errors and overflow
        for (int l = 0; l < 6; l++) begin
            int n = $urandom_range(0, 36);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b = 8'($urandom_range(0, 255));
                logic ok = ($urandom_range(0, 9) != 0);
                send_byte(b, ok);
                if (!ok) tick(3);
                if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 12));
            end
            send_byte(TERM, 1'b1);
            check_state("rand");
        end

        check("multi_pulse", 256'(multi_cnt), 256'(0));
        check("wide_pulse",  256'(wide_cnt),  256'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
